nonce_scheduler: RTL and testbench

NONCE_SCHEDULER -- requirements
Module: nonce_scheduler

---
 rtl/nonce_scheduler.sv | 144 ++++++++++++++
 tb/tb_nonce_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_scheduler.sv
// Nonce search sequencer: walks nonces from a base value, launches one hash
// per nonce, and stops on a hit, on nonce wrap-around, on a watchdog timeout,
// or on abort. The result flags stay set until the next accepted start.
module nonce_scheduler #(
    parameter logic [31:0] NONCE_STEP     = 32'd1,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic [31:0]     nonce_base,
    input  logic            hash_done,
    input  logic            hash_hit,
    output logic            selector,
    output logic [3:0][7:0] nonce,
    output logic            hash_start,
    output logic            busy,
    output logic            found,
    output logic            exhausted,
    output logic            timeout,
    output logic [31:0]     nonce_found,
    output logic [31:0]     attempts
);

    // The watchdog counts WAIT cycles already elapsed, so it only needs to hold TIMEOUT_CYCLES-1.
    localparam int unsigned WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_FOUND,
        S_EXHAUSTED,
        S_TMO
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     nonce_q, nonce_d;
    logic [31:0]     nonce_found_q, nonce_found_d;
    logic [31:0]     attempts_q, attempts_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            selector_q, hash_start_q, busy_q;
    logic            found_q, exhausted_q, timeout_q;
    logic [32:0]     next_sum_c;

    // 33-bit candidate for the next nonce; bit 32 flags wrap-around.
    assign next_sum_c = {1'b0, nonce_q} + {1'b0, NONCE_STEP};

    // Next-state and datapath update; abort overrides every other input.
    always_comb begin
        state_d       = state_q;
        nonce_d       = nonce_q;
        nonce_found_d = nonce_found_q;
        attempts_d    = attempts_q;
        wdog_d        = wdog_q;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_FOUND, S_EXHAUSTED, S_TMO: begin
                    if (start) begin
                        nonce_d    = nonce_base;
                        attempts_d = 32'd0;
                        state_d    = S_LOAD;
                    end
                end
                S_LOAD: begin
                    state_d = S_START;
                end
                S_START: begin
                    wdog_d  = '0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (hash_done) begin
                        if (attempts_q != 32'hFFFF_FFFF) begin
                            attempts_d = attempts_q + 32'd1;
                        end
                        if (hash_hit) begin
                            nonce_found_d = nonce_q;
                            state_d       = S_FOUND;
                        end else if (next_sum_c[32]) begin
                            state_d = S_EXHAUSTED;
                        end else begin
                            nonce_d = next_sum_c[31:0];
                            state_d = S_LOAD;
                        end
                    end else if (wdog_q == WD_LAST) begin
                        state_d = S_TMO;
                    end else begin
                        wdog_d = wdog_q + WD_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, datapath and output registers; outputs are precomputed from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            nonce_q       <= 32'd0;
            nonce_found_q <= 32'd0;
            attempts_q    <= 32'd0;
            wdog_q        <= '0;
            selector_q    <= 1'b0;
            hash_start_q  <= 1'b0;
            busy_q        <= 1'b0;
            found_q       <= 1'b0;
            exhausted_q   <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            nonce_q       <= nonce_d;
            nonce_found_q <= nonce_found_d;
            attempts_q    <= attempts_d;
            wdog_q        <= wdog_d;
            selector_q    <= (state_d == S_LOAD) || (state_d == S_START) || (state_d == S_WAIT);
            busy_q        <= (state_d == S_LOAD) || (state_d == S_START) || (state_d == S_WAIT);
            hash_start_q  <= (state_d == S_START);
            found_q       <= (state_d == S_FOUND);
            exhausted_q   <= (state_d == S_EXHAUSTED);
            timeout_q     <= (state_d == S_TMO);
        end
    end

    assign selector    = selector_q;
    assign nonce       = nonce_q;
    assign hash_start  = hash_start_q;
    assign busy        = busy_q;
    assign found       = found_q;
    assign exhausted   = exhausted_q;
    assign timeout     = timeout_q;
    assign nonce_found = nonce_found_q;
    assign attempts    = attempts_q;

endmodule

// File: tb/tb_nonce_scheduler.sv
// Scoreboard bench for nonce_scheduler: a search-level model predicts the
// nonce of every hash launch and the final outcome of every search.
module tb_nonce_scheduler;

    localparam logic [31:0] STEP = 32'd1;
    localparam int unsigned TMO  = 64;

    localparam int K_MISS  = 0;
    localparam int K_HIT   = 1;
    localparam int K_TMO   = 2;
    localparam int K_ABORT = 3;
    localparam int K_RESET = 4;

    typedef struct packed {
        logic        found;
        logic        exh;
        logic        tmo;
        logic        chk_nf;
        logic [31:0] nonce;
        logic [31:0] nf;
        logic [31:0] att;
    } res_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [31:0]     nonce_base = 32'd0;
    logic            hash_done = 1'b0;
    logic            hash_hit = 1'b0;
    logic            selector;
    logic [3:0][7:0] nonce;
    logic            hash_start;
    logic            busy;
    logic            found;
    logic            exhausted;
    logic            timeout;
    logic [31:0]     nonce_found;
    logic [31:0]     attempts;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_nonce_q[$];
    res_t        exp_res_q[$];

    nonce_scheduler #(
        .NONCE_STEP     (STEP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .nonce_base  (nonce_base),
        .hash_done   (hash_done),
        .hash_hit    (hash_hit),
        .selector    (selector),
        .nonce       (nonce),
        .hash_start  (hash_start),
        .busy        (busy),
        .found       (found),
        .exhausted   (exhausted),
        .timeout     (timeout),
        .nonce_found (nonce_found),
        .attempts    (attempts)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: checks each hash launch and each search outcome against the queues.
    int          cyc = 0;
    int          last_hs = -1;
    logic        busy_prev = 1'b0;
    logic [31:0] mon_exp_nonce;
    res_t        mon_r;
    always @(negedge clk) begin
        cyc++;
        if (hash_start) begin
            if (exp_nonce_q.size() == 0) begin
                check("hs_unexpected", 64'd1, 64'd0);
            end else begin
                mon_exp_nonce = exp_nonce_q.pop_front();
                check("hs_nonce", 64'(32'(nonce)), 64'(mon_exp_nonce));
            end
            check("hs_selector_busy", {62'd0, selector, busy}, 64'd3);
            if (last_hs >= 0) check("hs_gap_ge3", 64'(((cyc - last_hs) >= 3) ? 1 : 0), 64'd1);
            last_hs = cyc;
        end
        if (busy_prev && !busy) begin
            if (exp_res_q.size() == 0) begin
                check("res_unexpected", 64'd1, 64'd0);
            end else begin
                mon_r = exp_res_q.pop_front();
                check("res_found", 64'(found), 64'(mon_r.found));
                check("res_exhausted", 64'(exhausted), 64'(mon_r.exh));
                check("res_timeout", 64'(timeout), 64'(mon_r.tmo));
                check("res_nonce", 64'(32'(nonce)), 64'(mon_r.nonce));
                check("res_attempts", 64'(attempts), 64'(mon_r.att));
                check("res_sel_hs_idle", {62'd0, selector, hash_start}, 64'd0);
                if (mon_r.chk_nf) check("res_nonce_found", 64'(nonce_found), 64'(mon_r.nf));
            end
        end
        busy_prev = busy;
    end

    // One search: model the outcome, queue expectations, then act as the hash engine.
    task automatic run_search(input logic [31:0] base, input int n_att, input int last_kind,
                              input int last_lat, input int miss_lat);
        logic [31:0] n;
        logic [31:0] att;
        longint      s;
        int          kinds[$];
        int          lats[$];
        int          kind;
        int          lat;
        int          cnt;
        logic        ok;
        res_t        r;

        n = base;
        att = 32'd0;
        r = '0;
        for (int k = 0; k < n_att; k++) begin
            kind = (k == n_att - 1) ? last_kind : K_MISS;
            lat  = (k == n_att - 1) ? last_lat : ((miss_lat > 0) ? miss_lat : int'($urandom_range(1, 4)));
            kinds.push_back(kind);
            lats.push_back(lat);
            exp_nonce_q.push_back(n);
            if (kind == K_MISS) begin
                att = att + 32'd1;
                s = longint'(n) + longint'(STEP);
                if (s > 64'h0000_0000_FFFF_FFFF) begin
                    r.exh = 1'b1;
                    break;
                end
                n = 32'(s);
            end else if (kind == K_HIT) begin
                att = att + 32'd1;
                r.found = 1'b1;
                r.nf = n;
                r.chk_nf = 1'b1;
                break;
            end else if (kind == K_TMO) begin
                r.tmo = 1'b1;
                break;
            end else if (kind == K_ABORT) begin
                break;
            end else begin
                n = 32'd0;
                att = 32'd0;
                r.nf = 32'd0;
                r.chk_nf = 1'b1;
                break;
            end
        end
        r.nonce = n;
        r.att = att;
        exp_res_q.push_back(r);

        @(negedge clk);
        start = 1'b1;
        nonce_base = base;
        @(negedge clk);
        start = 1'b0;
        nonce_base = $urandom;

        for (int k = 0; k < kinds.size(); k++) begin
            ok = 1'b0;
            for (int t = 0; t < 10 && !ok; t++) begin
                if (hash_start) ok = 1'b1;
                else @(negedge clk);
            end
            if (!ok) begin
                check("hs_wait_expired", 64'd0, 64'd1);
                break;
            end
            case (kinds[k])
                K_MISS, K_HIT: begin
                    repeat (lats[k]) @(negedge clk);
                    hash_done = 1'b1;
                    hash_hit = (kinds[k] == K_HIT);
                    @(negedge clk);
                    hash_done = 1'b0;
                    hash_hit = 1'b0;
                end
                K_TMO: begin
                    cnt = 0;
                    while (!timeout && cnt < 200) begin
                        @(negedge clk);
                        cnt++;
                    end
                    check("tmo_cycle", 64'(cnt), 64'(TMO + 1));
                end
                K_ABORT: begin
                    repeat (lats[k]) @(negedge clk);
                    abort = 1'b1;
                    hash_done = 1'b1;
                    hash_hit = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    hash_done = 1'b0;
                    hash_hit = 1'b0;
                end
                default: begin
                    repeat (lats[k]) @(negedge clk);
                    #3 reset = 1'b1;
                    #1;
                    check("async_rst_flags", {58'd0, selector, hash_start, busy, found, exhausted, timeout}, 64'd0);
                    check("async_rst_regs", 64'(32'(nonce) | nonce_found | attempts), 64'd0);
                    @(negedge clk);
                    reset = 1'b0;
                    hash_done = 1'b1;
                    hash_hit = 1'b1;
                    @(negedge clk);
                    hash_done = 1'b0;
                    hash_hit = 1'b0;
                    @(negedge clk);
                    check("done_after_reset_ignored", {62'd0, busy, found}, 64'd0);
                end
            endcase
        end

        cnt = 0;
        while (busy && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        if (busy) check("search_end_expired", 64'd1, 64'd0);
        @(negedge clk);
    endtask

    int          kind_r;
    logic [31:0] base_r;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_flags", {58'd0, selector, hash_start, busy, found, exhausted, timeout}, 64'd0);
        check("reset_regs", 64'(32'(nonce) | nonce_found | attempts), 64'd0);
        reset = 1'b0;
        hash_done = 1'b1;
        hash_hit = 1'b1;
        repeat (2) @(negedge clk);
        hash_done = 1'b0;
        hash_hit = 1'b0;
        check("idle_after_reset", {61'd0, busy, found, attempts[0]}, 64'd0);

        // Basic hit on the first WAIT cycle.
        run_search(32'h0000_0010, 1, K_HIT, 1, 0);
        // A hash_done while in FOUND must change nothing.
        hash_done = 1'b1;
        hash_hit = 1'b0;
        @(negedge clk);
        hash_done = 1'b0;
        @(negedge clk);
        check("found_ignores_done", {31'd0, found, attempts}, {31'd0, 1'b1, 32'd1});

        // Two misses then a hit, minimum spacing.
        run_search(32'h0000_0100, 3, K_HIT, 1, 1);
        // Wrap-around ends the search.
        run_search(32'hFFFF_FFFE, 2, K_MISS, 2, 0);
        // Watchdog expiry, then hash_done on the last allowed WAIT cycle (hit and miss).
        run_search($urandom_range(0, 32'h0FFF_FFFF), 2, K_TMO, 0, 0);
        run_search($urandom_range(0, 32'h0FFF_FFFF), 1, K_HIT, int'(TMO), 0);
        run_search($urandom_range(0, 32'h0FFF_FFFF), 2, K_HIT, 2, int'(TMO));
        // Abort colliding with a hit, then asynchronous reset mid-WAIT.
        run_search(32'h0000_0200, 2, K_ABORT, 1, 0);
        run_search(32'h0000_0300, 2, K_RESET, 2, 0);

        // Randomized searches.
        for (int i = 0; i < 10; i++) begin
            base_r = $urandom_range(0, 32'h7FFF_FFFF);
            case ($urandom_range(0, 3))
                0: kind_r = K_TMO;
                1: kind_r = K_ABORT;
                default: kind_r = K_HIT;
            endcase
            run_search(base_r, int'($urandom_range(1, 4)), kind_r, int'($urandom_range(1, 6)), 0);
        end

        check("nonce_queue_drained", 64'(exp_nonce_q.size()), 64'd0);
        check("result_queue_drained", 64'(exp_res_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Hard stop in case the bench itself wedges.
    initial begin
        #500000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1);
    end

endmodule
